// File: rtl/fetch_queue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_queue_stage: PC owner and I-cache requester feeding decode from a    |
// | DEPTH-entry instruction queue; optional FETCH_PERF_EN adds perf counters.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module fetch_queue_stage #(
    parameter int              XLEN     = 64,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            CLK,
    input  logic            reset,
    input  logic            redirect_trap,
    input  logic [XLEN-1:0] trap_vec,
    input  logic            redirect_br,
    input  logic [XLEN-1:0] br_target,
    output logic            ic_req_valid,
    input  logic            ic_req_ready,
    output logic [XLEN-1:0] ic_req_addr,
    input  logic            ic_rsp_valid,
    input  logic [31:0]     ic_rsp_instr,
    input  logic            ic_rsp_fault,
    output logic            DE_V,
    output logic [31:0]     DE_IR,
    output logic [XLEN-1:0] DE_PC,
    output logic [XLEN-1:0] DE_NPC,
    output logic            DE_IAM,
    output logic            DE_IAF,
    input  logic            de_ready
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_flushed
`endif
);

    localparam int              AW      = $clog2(DEPTH);
    localparam int              CW      = AW + 1;
    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);
    localparam logic [CW-1:0]   FULL    = CW'(DEPTH);

    typedef enum logic [1:0] {
        S_RUN   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic [AW-1:0]   head_q, head_d;
    logic [AW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;

    logic [XLEN-1:0] mem_pc_q  [DEPTH];
    logic [31:0]     mem_ir_q  [DEPTH];
    logic            mem_iam_q [DEPTH];
    logic            mem_iaf_q [DEPTH];

    logic            w_redirect;
    logic [XLEN-1:0] w_target;
    logic            w_misal;
    logic            w_room;
    logic            w_accept;
    logic            w_pop;
    logic            w_push;
    logic [XLEN-1:0] w_push_pc;
    logic [31:0]     w_push_ir;
    logic            w_push_iam;
    logic            w_push_iaf;

    assign w_redirect   = redirect_trap | redirect_br;
    assign w_target     = redirect_trap ? trap_vec : br_target;
    assign w_misal      = (pc_q[1:0] != 2'b00);
    assign w_room       = (count_q != FULL);
    assign ic_req_valid = !reset && (state_q == S_RUN) && !w_misal && w_room;
    assign ic_req_addr  = pc_q;
    assign w_accept     = ic_req_valid && ic_req_ready;

    assign DE_V   = (count_q != '0);
    assign DE_IR  = DE_V ? mem_ir_q[head_q]  : 32'd0;
    assign DE_PC  = DE_V ? mem_pc_q[head_q]  : '0;
    assign DE_IAM = DE_V ? mem_iam_q[head_q] : 1'b0;
    assign DE_IAF = DE_V ? mem_iaf_q[head_q] : 1'b0;
    assign DE_NPC = DE_PC + PC_STEP;
    assign w_pop  = DE_V && de_ready;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        w_push     = 1'b0;
        w_push_pc  = pc_q;
        w_push_ir  = 32'd0;
        w_push_iam = 1'b0;
        w_push_iaf = 1'b0;

        case (state_q)
            S_RUN: begin
                if (w_misal) begin
                    if (w_room) begin
                        w_push     = 1'b1;
                        w_push_iam = 1'b1;
                        state_d    = S_HALT;
                    end
                end else if (w_accept) begin
                    req_pc_d = pc_q;
                    pc_d     = pc_q + PC_STEP;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (ic_rsp_valid) begin
                    w_push     = 1'b1;
                    w_push_pc  = req_pc_q;
                    w_push_ir  = ic_rsp_instr;
                    w_push_iaf = ic_rsp_fault;
                    state_d    = ic_rsp_fault ? S_HALT : S_RUN;
                end
            end
            S_DRAIN: begin
                if (ic_rsp_valid) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = state_q;
            end
        endcase

        // A response landing in the redirect cycle retires the outstanding request.
        if (w_redirect) begin
            w_push = 1'b0;
            pc_d   = w_target;
            if (w_accept ||
                (((state_q == S_WAIT) || (state_q == S_DRAIN)) && !ic_rsp_valid)) begin
                state_d = S_DRAIN;
            end else begin
                state_d = S_RUN;
            end
        end
    end

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (w_redirect) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (w_push) begin
                tail_d = tail_q + AW'(1);
            end
            if (w_pop) begin
                head_d = head_q + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q  <= S_RUN;
            pc_q     <= RESET_PC;
            req_pc_q <= '0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (w_push) begin
            mem_pc_q[tail_q]  <= w_push_pc;
            mem_ir_q[tail_q]  <= w_push_ir;
            mem_iam_q[tail_q] <= w_push_iam;
            mem_iaf_q[tail_q] <= w_push_iaf;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_flushed_q;

    always_ff @(posedge CLK) begin
        if (reset) begin
            perf_fetched_q <= 32'd0;
            perf_flushed_q <= 32'd0;
        end else begin
            if (w_pop && !w_redirect) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (w_redirect) begin
                perf_flushed_q <= perf_flushed_q + 32'(count_q);
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_flushed = perf_flushed_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_queue_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_queue_stage: directed self-checking bench for fetch_queue_stage.  |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_fetch_queue_stage;

    logic        CLK;
    logic        reset;
    logic        redirect_trap;
    logic [63:0] trap_vec;
    logic        redirect_br;
    logic [63:0] br_target;
    logic        ic_req_valid;
    logic        ic_req_ready;
    logic [63:0] ic_req_addr;
    logic        ic_rsp_valid;
    logic [31:0] ic_rsp_instr;
    logic        ic_rsp_fault;
    logic        DE_V;
    logic [31:0] DE_IR;
    logic [63:0] DE_PC;
    logic [63:0] DE_NPC;
    logic        DE_IAM;
    logic        DE_IAF;
    logic        de_ready;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_flushed;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // Cache model controls
    int          lat = 1;
    logic        fault_en = 1'b0;
    logic [63:0] fault_addr = '0;
    logic        pend = 1'b0;
    int          cnt = 0;
    logic [63:0] paddr = '0;

    fetch_queue_stage #(.XLEN(64), .DEPTH(4), .RESET_PC(64'h0)) dut (
        .CLK           (CLK),
        .reset         (reset),
        .redirect_trap (redirect_trap),
        .trap_vec      (trap_vec),
        .redirect_br   (redirect_br),
        .br_target     (br_target),
        .ic_req_valid  (ic_req_valid),
        .ic_req_ready  (ic_req_ready),
        .ic_req_addr   (ic_req_addr),
        .ic_rsp_valid  (ic_rsp_valid),
        .ic_rsp_instr  (ic_rsp_instr),
        .ic_rsp_fault  (ic_rsp_fault),
        .DE_V          (DE_V),
        .DE_IR         (DE_IR),
        .DE_PC         (DE_PC),
        .DE_NPC        (DE_NPC),
        .DE_IAM        (DE_IAM),
        .DE_IAF        (DE_IAF),
        .de_ready      (de_ready)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched  (perf_fetched),
        .perf_flushed  (perf_flushed)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return a[31:0] ^ 32'hDEAD_0013;
    endfunction

    // Cache responds lat cycles after acceptance (lat=1: sampled on the next edge).
    always @(posedge CLK) begin
        ic_rsp_valid <= 1'b0;
        ic_rsp_fault <= 1'b0;
        if (reset) begin
            pend <= 1'b0;
        end else begin
            if (pend) begin
                if (cnt <= 1) begin
                    ic_rsp_valid <= 1'b1;
                    ic_rsp_instr <= instr_of(paddr);
                    ic_rsp_fault <= fault_en && (paddr == fault_addr);
                    pend         <= 1'b0;
                end else begin
                    cnt <= cnt - 1;
                end
            end
            if (ic_req_valid && ic_req_ready) begin
                if (lat <= 1) begin
                    ic_rsp_valid <= 1'b1;
                    ic_rsp_instr <= instr_of(ic_req_addr);
                    ic_rsp_fault <= fault_en && (ic_req_addr == fault_addr);
                end else begin
                    pend  <= 1'b1;
                    cnt   <= lat - 1;
                    paddr <= ic_req_addr;
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_dev(input string tag);
        int n = 0;
        while (DE_V !== 1'b1 && n < 12) begin
            @(negedge CLK);
            n++;
        end
        chk(tag, {63'd0, DE_V}, 64'd1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge CLK);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; redirect_trap = 1'b0; redirect_br = 1'b0;
        trap_vec = '0; br_target = '0; ic_req_ready = 1'b1; de_ready = 1'b1;
        ic_rsp_valid = 1'b0; ic_rsp_instr = '0; ic_rsp_fault = 1'b0;
        repeat (3) @(negedge CLK);

        // Reset state
        chk("rst_de_v",   {63'd0, DE_V}, 64'd0);
        chk("rst_de_pc",  DE_PC, 64'd0);
        chk("rst_de_npc", DE_NPC, 64'd4);
        chk("rst_de_ir",  {32'd0, DE_IR}, 64'd0);
        chk("rst_iam_iaf", {62'd0, DE_IAM, DE_IAF}, 64'd0);
        chk("rst_req_v",  {63'd0, ic_req_valid}, 64'd0);
        reset = 1'b0;

        // Streaming fetch with 1-cycle cache
        @(negedge CLK);
        chk("t1_wait_req", {63'd0, ic_req_valid}, 64'd0);
        chk("t1_wait_dev", {63'd0, DE_V}, 64'd0);
        @(negedge CLK);
        chk("t1_dev0", {63'd0, DE_V}, 64'd1);
        chk("t1_pc0",  DE_PC, 64'h0);
        chk("t1_npc0", DE_NPC, 64'h4);
        chk("t1_ir0",  {32'd0, DE_IR}, {32'd0, instr_of(64'h0)});
        chk("t1_addr4", ic_req_addr, 64'h4);
        @(negedge CLK);
        chk("t1_empty", {63'd0, DE_V}, 64'd0);
        @(negedge CLK);
        chk("t1_pc4",  DE_PC, 64'h4);
        chk("t1_npc4", DE_NPC, 64'h8);
        repeat (2) @(negedge CLK);
        chk("t1_pc8",  DE_PC, 64'h8);

        // Back-pressure: queue fills to DEPTH, then drains in order
        de_ready = 1'b0;
        repeat (20) @(negedge CLK);
        chk("t2_full_req", {63'd0, ic_req_valid}, 64'd0);
        chk("t2_full_head", DE_PC, 64'h8);
        de_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("t2_order", DE_PC, 64'h8 + 64'(4 * i));
            @(negedge CLK);
        end

        // Branch redirect while a slow response is outstanding
        de_ready = 1'b0; lat = 1;
        do_reset();
        repeat (4) @(negedge CLK);
        lat = 3;
        @(negedge CLK);
        chk("t3_pre_head", DE_PC, 64'h0);
        redirect_br = 1'b1; br_target = 64'h100;
        @(negedge CLK);
        redirect_br = 1'b0;
        chk("t3_flush", {63'd0, DE_V}, 64'd0);
        chk("t3_drain_req", {63'd0, ic_req_valid}, 64'd0);
        repeat (2) @(negedge CLK);
        chk("t3_stale", {63'd0, DE_V}, 64'd0);
        chk("t3_req_addr", ic_req_addr, 64'h100);
        chk("t3_req_v", {63'd0, ic_req_valid}, 64'd1);
        wait_dev("t3_dev");
        chk("t3_pc", DE_PC, 64'h100);
        chk("t3_ir", {32'd0, DE_IR}, {32'd0, instr_of(64'h100)});

        // Trap and branch in the same cycle as a request acceptance
        lat = 1; de_ready = 1'b1;
        do_reset();
        redirect_trap = 1'b1; trap_vec = 64'h200;
        redirect_br = 1'b1; br_target = 64'h100;
        @(negedge CLK);
        redirect_trap = 1'b0; redirect_br = 1'b0;
        chk("t4_drain_req", {63'd0, ic_req_valid}, 64'd0);
        @(negedge CLK);
        chk("t4_dropped", {63'd0, DE_V}, 64'd0);
        chk("t4_req_addr", ic_req_addr, 64'h200);
        wait_dev("t4_dev");
        chk("t4_pc", DE_PC, 64'h200);

        // Misaligned target
        ic_req_ready = 1'b0; de_ready = 1'b0;
        do_reset();
        redirect_br = 1'b1; br_target = 64'h102;
        @(negedge CLK);
        redirect_br = 1'b0;
        chk("t5_no_req", {63'd0, ic_req_valid}, 64'd0);
        @(negedge CLK);
        chk("t5_dev", {63'd0, DE_V}, 64'd1);
        chk("t5_pc",  DE_PC, 64'h102);
        chk("t5_npc", DE_NPC, 64'h106);
        chk("t5_iam_iaf", {62'd0, DE_IAM, DE_IAF}, 64'd2);
        chk("t5_ir",  {32'd0, DE_IR}, 64'd0);
        ic_req_ready = 1'b1; de_ready = 1'b1;
        repeat (6) @(negedge CLK);
        chk("t5_halt_req", {63'd0, ic_req_valid}, 64'd0);
        chk("t5_halt_dev", {63'd0, DE_V}, 64'd0);

        // Access fault halts fetch until a redirect
        fault_en = 1'b1; fault_addr = 64'h40;
        redirect_br = 1'b1; br_target = 64'h40;
        @(negedge CLK);
        redirect_br = 1'b0;
        wait_dev("t6_dev");
        chk("t6_pc", DE_PC, 64'h40);
        chk("t6_iam_iaf", {62'd0, DE_IAM, DE_IAF}, 64'd1);
        repeat (4) @(negedge CLK);
        chk("t6_halt_req", {63'd0, ic_req_valid}, 64'd0);
        chk("t6_halt_dev", {63'd0, DE_V}, 64'd0);
        fault_en = 1'b0;
        redirect_br = 1'b1; br_target = 64'h80;
        @(negedge CLK);
        redirect_br = 1'b0;
        wait_dev("t6_resume_dev");
        chk("t6_resume_pc", DE_PC, 64'h80);
        chk("t6_resume_iaf", {63'd0, DE_IAF}, 64'd0);

        // PC wrap at the top of the address space
        redirect_br = 1'b1; br_target = 64'hFFFF_FFFF_FFFF_FFFC;
        @(negedge CLK);
        redirect_br = 1'b0;
        wait_dev("t7_dev");
        chk("t7_pc",  DE_PC, 64'hFFFF_FFFF_FFFF_FFFC);
        chk("t7_npc", DE_NPC, 64'h0);
        @(negedge CLK);
        wait_dev("t7_dev_wrap");
        chk("t7_pc_wrap", DE_PC, 64'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_queue_stage.md
Name: fetch_queue_stage

Overview:
Parametrised successor to the single-entry fetch stage. Owns the PC and issues requests to the instruction cache over a valid/ready request port and a valid response port. It buffers fetched instructions, together with their PC and fault flags, in a DEPTH-entry queue that feeds decode through a valid/ready handshake. Branch and trap redirects flush the queue and discard any in-flight response.

Parameters:
XLEN, 64, PC/address width
DEPTH, 4, instruction queue entries (power of two, >=2)
RESET_PC, 0, PC value loaded on reset

Ports:
CLK  in  1  clock
reset  in  1  synchronous, active-high reset
redirect_trap  in  1  trap redirect request (highest priority)
trap_vec  in  XLEN  trap target (mtvec)
redirect_br  in  1  branch/jump redirect request
br_target  in  XLEN  branch/jump target
ic_req_valid  out  1  cache request valid
ic_req_ready  in  1  cache accepts request
ic_req_addr  out  XLEN  request address (= PC)
ic_rsp_valid  in  1  cache response valid, one cycle
ic_rsp_instr  in  32  fetched instruction
ic_rsp_fault  in  1  access fault for the response
DE_V  out  1  queue head valid
DE_IR  out  32  head instruction
DE_PC  out  XLEN  head PC
DE_NPC  out  XLEN  head PC + 4
DE_IAM  out  1  head has instruction-address-misaligned fault
DE_IAF  out  1  head has instruction access fault
de_ready  in  1  decode consumes head when DE_V && de_ready

Behaviour:
- Reset (synchronous, active-high; clock CLK):
  - PC = RESET_PC; queue empty; state RUN.
  - DE_V=0, DE_IR=0, DE_PC=0, DE_NPC=4, DE_IAM=0, DE_IAF=0, ic_req_valid=0.
  - Reset mid-transaction abandons any outstanding request; a response arriving after reset is dropped.
- Queue: circular buffer of {pc, instr, iam, iaf}; count is 0..DEPTH. DE_* outputs are driven from the head entry; DE_V = (count != 0). Push and pop in the same cycle leave count unchanged.
- At most one cache request is outstanding. A free slot is reserved for it, so a response never finds the queue full.
- States:
  - RUN
    - If PC[1:0] != 0: no request is issued. When count < DEPTH, push {PC, 0, iam=1, iaf=0} and go to HALT.
    - Else if count < DEPTH: ic_req_valid=1 and ic_req_addr=PC. On ic_req_ready, go to WAIT with PC += 4.
  - WAIT
    - ic_req_valid=0.
    - On ic_rsp_valid, push {PC_of_req, instr, 0, fault}.
    - If fault, go to HALT; otherwise go to RUN.
    - Fetch resumes one cycle after the response (no same-cycle reissue).
  - DRAIN
    - Entered when a redirect occurs in WAIT, or in RUN in the same cycle as the request is accepted.
    - The next ic_rsp_valid is discarded; the state then moves to RUN.
  - HALT
    - No fetching after a fault entry.
    - Exits only on a redirect.
- Redirect (redirect_trap || redirect_br) in cycle t:
  - Queue flushed, including any pop in cycle t.
  - PC = trap_vec if redirect_trap, else br_target.
  - DE_V=0 at t+1.
  - ic_req_valid may be withdrawn in cycle t if not yet accepted.
  - State becomes DRAIN if a response is outstanding, else RUN.
  - redirect_trap wins over redirect_br when both are asserted.
- A redirect in DRAIN keeps the state DRAIN with the new PC. A response arriving in the same cycle as that redirect counts as the drained one, and the state goes to RUN.
- PC arithmetic is modulo 2^XLEN; DE_NPC = DE_PC + 4 wraps.

Optional Feature:
FETCH_PERF_EN
- Defined: adds outputs perf_fetched[31:0] and perf_flushed[31:0].
  - perf_fetched increments on every queue pop.
  - perf_flushed increments by the number of entries discarded on each redirect.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, ic_req_ready=1, cache returns the response 1 cycle after acceptance, de_ready=1 -> DE_PC sequence 0x0, 0x4, 0x8; DE_NPC = DE_PC+4; DE_V=1 from the first response +1 cycle.
- de_ready=0 for 20 cycles -> count saturates at 4; ic_req_valid=0 while full; no entry lost or duplicated when de_ready returns to 1.
- redirect_br with br_target=0x100 while a request is outstanding -> queue empty next cycle; stale response dropped; next DE_PC = 0x100.
- redirect_trap (trap_vec=0x200) and redirect_br (br_target=0x100) asserted in the same cycle -> fetch resumes at 0x200.
- br_target=0x102 -> single entry with DE_IAM=1 and DE_PC=0x102; no cache request issued; fetch halted until the next redirect.
- ic_rsp_fault=1 at PC 0x40 -> entry with DE_IAF=1; no further requests; redirect to 0x80 resumes fetch.
